hwpf_prefetch_responder: RTL
============================

Name: hwpf_prefetch_responder

Overview:
- Cache-side responder for the hardware prefetcher's CMO-prefetch request channel.
- Accepts cacheline prefetch requests and merges duplicates of lines already in flight.
- Tracks misses in a small in-flight table, issues one memory refill read per distinct line, and returns exactly one response per accepted request. The prefetcher's in-flight counter therefore stays balanced.
- Sits between the prefetcher request/response ports and the memory refill interface.

Parameters:
NLINE_WIDTH, 50, cacheline-number width (PA width minus offset width).
TID_WIDTH, 6, transaction id width, echoed in responses.
N_ENTRIES, 4, in-flight table depth (≥2).
ID_WIDTH, $clog2(N_ENTRIES), derived; memory transaction id width (entry index).

Ports:
clk_i  in  1  clock.
rst_ni  in  1  asynchronous active-low reset.
req_valid_i  in  1  prefetch request valid.
req_ready_o  out  1  request accepted when valid&&ready.
req_nline_i  in  NLINE_WIDTH  cacheline number to prefetch.
req_tid_i  in  TID_WIDTH  request id.
rsp_valid_o  out  1  one-cycle response pulse; no back-pressure.
rsp_tid_o  out  TID_WIDTH  id of the completed request.
rsp_merged_o  out  1  1 = request merged into an existing in-flight entry.
mem_req_valid_o  out  1  refill read valid.
mem_req_ready_i  in  1  refill read accepted.
mem_req_nline_o  out  NLINE_WIDTH  line to read.
mem_req_id_o  out  ID_WIDTH  table entry index.
mem_rsp_valid_i  in  1  refill complete.
mem_rsp_id_i  in  ID_WIDTH  completed entry index.
busy_o  out  1  any entry not FREE, or rsp_valid_o high.
err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_ni, asynchronous, active-low; clock clk_i): all entries FREE; rsp_valid_o, rsp_merged_o, mem_req_valid_o, busy_o, err_o = 0; rsp_tid_o, mem_req_nline_o, mem_req_id_o = 0.
- Reset mid-operation: table, outputs and error cleared immediately; pending responses are discarded.
- Per-entry FSM:
  - FREE -> PENDING on allocation.
  - PENDING -> QUEUED when loaded into the mem request register.
  - QUEUED -> SENT on mem_req_valid_o && mem_req_ready_i.
  - SENT -> FREE on mem_rsp_valid_i with a matching id.
  - Each entry stores nline and tid.
- req_ready_o = !full && !mem_rsp_valid_i (combinational). full = no FREE entry. A completion cycle therefore never coincides with an acceptance.
- On acceptance, compare req_nline_i against the nline of every non-FREE entry (registered table state):
  - Hit: no allocation. Next cycle rsp_valid_o=1, rsp_tid_o=req_tid_i, rsp_merged_o=1.
  - Miss: allocate the lowest-index FREE entry, which becomes PENDING at the next edge. No immediate response.
- Mem request register update: when !mem_req_valid_o || mem_req_ready_i, load the lowest-index PENDING entry (valid=1, nline, id=index; entry -> QUEUED). If none is PENDING, mem_req_valid_o drops to 0.
- Outputs are held stable while valid && !ready.
- Latency:
  - Miss accepted in cycle t -> mem_req_valid_o at t+2 if the register is idle.
  - Back-to-back issue is possible at one line per cycle.
- Memory completion: mem_rsp_valid_i in cycle t with id of a SENT entry -> at t+1 rsp_valid_o=1, rsp_tid_o=entry tid, rsp_merged_o=0. The entry is FREE at t+1 and visible in req_ready_o at t+1.
- Merged requests complete at merge time (next cycle), not at refill time. The response count always equals the accepted-request count.
- Protocol error: mem_rsp_valid_i with an id whose entry is not SENT sets err_o (sticky until reset), is otherwise ignored, and produces no response.
- Duplicate nlines never occupy two entries simultaneously.

Test Plan:
- Single miss: req nline=0x100, tid=3, mem ready=1; mem_rsp id=0 five cycles later -> mem_req_valid_o at t+2 with nline 0x100, id 0; rsp_valid_o one cycle after mem_rsp with tid=3, merged=0; busy_o returns to 0.
- Merge: req 0x200 tid=1, then 0x200 tid=2 before the refill returns -> tid=2 response next cycle with merged=1; only one mem request issued; tid=1 response after its mem_rsp.
- Full table: N_ENTRIES=4, mem_rsp withheld, 5 distinct requests -> the first 4 are accepted and req_ready_o=0 for the 5th. mem_rsp id=2 -> ready=1 the cycle after; the 5th request allocates entry 2.
- Back-pressure: mem_req_ready_i=0 for 3 cycles with 2 pending -> mem_req_nline_o/id stable; when ready rises, entries issue in index order on consecutive cycles.
- Completion vs request collision: mem_rsp_valid_i high while req_valid_i is high -> req_ready_o=0 that cycle; the request is accepted the next cycle; responses are never lost or merged.
- Error and reset: mem_rsp id=3 with entry 3 FREE -> err_o=1, no rsp. Assert rst_ni low mid-refill -> all outputs 0, and a subsequent request allocates entry 0.

Source files
------------

// File: rtl/hwpf_prefetch_responder_if.sv
// Prefetch request/response and memory refill handshake bundle for hwpf_prefetch_responder.
// The master side is the prefetcher plus memory model; the slave side is the responder.
interface hwpf_prefetch_responder_if #(
  parameter int NLINE_WIDTH = 50,
  parameter int TID_WIDTH   = 6,
  parameter int ID_WIDTH    = 2
);
  logic                   req_valid_i;
  logic                   req_ready_o;
  logic [NLINE_WIDTH-1:0] req_nline_i;
  logic [TID_WIDTH-1:0]   req_tid_i;
  logic                   rsp_valid_o;
  logic [TID_WIDTH-1:0]   rsp_tid_o;
  logic                   rsp_merged_o;
  logic                   mem_req_valid_o;
  logic                   mem_req_ready_i;
  logic [NLINE_WIDTH-1:0] mem_req_nline_o;
  logic [ID_WIDTH-1:0]    mem_req_id_o;
  logic                   mem_rsp_valid_i;
  logic [ID_WIDTH-1:0]    mem_rsp_id_i;

  modport master (
    output req_valid_i, req_nline_i, req_tid_i, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_id_i,
    input  req_ready_o, rsp_valid_o, rsp_tid_o, rsp_merged_o,
           mem_req_valid_o, mem_req_nline_o, mem_req_id_o
  );

  modport slave (
    input  req_valid_i, req_nline_i, req_tid_i, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_id_i,
    output req_ready_o, rsp_valid_o, rsp_tid_o, rsp_merged_o,
           mem_req_valid_o, mem_req_nline_o, mem_req_id_o
  );
endinterface

// File: rtl/hwpf_prefetch_responder.sv
// Prefetch responder: merges duplicate lines, one refill per distinct line, one response per request.
// Miss -> mem request 2 cycles later; mem request held while !ready; req_ready drops when full or on completion.
module hwpf_prefetch_responder #(
  parameter int NLINE_WIDTH = 50,
  parameter int TID_WIDTH   = 6,
  parameter int N_ENTRIES   = 4,
  parameter int ID_WIDTH    = $clog2(N_ENTRIES)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  hwpf_prefetch_responder_if.slave  bus,
  output logic                      busy_o,
  output logic                      err_o
);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_PENDING,
    ST_QUEUED,
    ST_SENT
  } ent_state_e;

  ent_state_e             state_q [N_ENTRIES];
  ent_state_e             state_d [N_ENTRIES];
  logic [NLINE_WIDTH-1:0] nline_q [N_ENTRIES];
  logic [TID_WIDTH-1:0]   tid_q   [N_ENTRIES];

  logic                   mreq_vld_q, mreq_vld_d;
  logic [NLINE_WIDTH-1:0] mreq_nline_q, mreq_nline_d;
  logic [ID_WIDTH-1:0]    mreq_id_q, mreq_id_d;

  logic                   rsp_vld_q, rsp_vld_d;
  logic [TID_WIDTH-1:0]   rsp_tid_q, rsp_tid_d;
  logic                   rsp_merged_q, rsp_merged_d;
  logic                   err_q, err_d;

  logic                   any_free, any_pend, any_busy, hit, cpl_ok;
  logic [ID_WIDTH-1:0]    alloc_idx, pend_idx;
  logic [NLINE_WIDTH-1:0] pend_nline;
  logic [TID_WIDTH-1:0]   cpl_tid;
  logic                   req_rdy, accept, alloc, mreq_fire, mreq_load, cpl_vld;

  // Descending scan so the lowest matching index wins.
  always_comb begin
    any_free   = 1'b0;
    any_pend   = 1'b0;
    any_busy   = 1'b0;
    hit        = 1'b0;
    cpl_ok     = 1'b0;
    alloc_idx  = '0;
    pend_idx   = '0;
    pend_nline = '0;
    cpl_tid    = '0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (state_q[i] == ST_FREE) begin
        any_free  = 1'b1;
        alloc_idx = ID_WIDTH'(i);
      end else begin
        any_busy = 1'b1;
        if (nline_q[i] == bus.req_nline_i) hit = 1'b1;
      end
      if (state_q[i] == ST_PENDING) begin
        any_pend   = 1'b1;
        pend_idx   = ID_WIDTH'(i);
        pend_nline = nline_q[i];
      end
      if (bus.mem_rsp_id_i == ID_WIDTH'(i) && state_q[i] == ST_SENT) begin
        cpl_ok  = 1'b1;
        cpl_tid = tid_q[i];
      end
    end
  end

  assign req_rdy   = any_free && !bus.mem_rsp_valid_i;
  assign accept    = bus.req_valid_i && req_rdy;
  assign alloc     = accept && !hit;
  assign mreq_fire = mreq_vld_q && bus.mem_req_ready_i;
  assign mreq_load = !mreq_vld_q || bus.mem_req_ready_i;
  assign cpl_vld   = bus.mem_rsp_valid_i && cpl_ok;

  always_comb begin
    for (int i = 0; i < N_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      unique case (state_q[i])
        ST_FREE:    if (alloc && alloc_idx == ID_WIDTH'(i)) state_d[i] = ST_PENDING;
        ST_PENDING: if (mreq_load && pend_idx == ID_WIDTH'(i)) state_d[i] = ST_QUEUED;
        ST_QUEUED:  if (mreq_fire && mreq_id_q == ID_WIDTH'(i)) state_d[i] = ST_SENT;
        ST_SENT:    if (bus.mem_rsp_valid_i && bus.mem_rsp_id_i == ID_WIDTH'(i)) state_d[i] = ST_FREE;
        default:    state_d[i] = ST_FREE;
      endcase
    end

    mreq_vld_d   = mreq_vld_q;
    mreq_nline_d = mreq_nline_q;
    mreq_id_d    = mreq_id_q;
    if (mreq_load) begin
      mreq_vld_d = any_pend;
      if (any_pend) begin
        mreq_nline_d = pend_nline;
        mreq_id_d    = pend_idx;
      end
    end

    // A merge and a completion never share a cycle: completions block acceptance.
    rsp_vld_d    = 1'b0;
    rsp_tid_d    = rsp_tid_q;
    rsp_merged_d = 1'b0;
    if (accept && hit) begin
      rsp_vld_d    = 1'b1;
      rsp_tid_d    = bus.req_tid_i;
      rsp_merged_d = 1'b1;
    end else if (cpl_vld) begin
      rsp_vld_d = 1'b1;
      rsp_tid_d = cpl_tid;
    end

    err_d = err_q || (bus.mem_rsp_valid_i && !cpl_ok);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        state_q[i] <= ST_FREE;
        nline_q[i] <= '0;
        tid_q[i]   <= '0;
      end
      mreq_vld_q   <= 1'b0;
      mreq_nline_q <= '0;
      mreq_id_q    <= '0;
      rsp_vld_q    <= 1'b0;
      rsp_tid_q    <= '0;
      rsp_merged_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        state_q[i] <= state_d[i];
        if (alloc && alloc_idx == ID_WIDTH'(i)) begin
          nline_q[i] <= bus.req_nline_i;
          tid_q[i]   <= bus.req_tid_i;
        end
      end
      mreq_vld_q   <= mreq_vld_d;
      mreq_nline_q <= mreq_nline_d;
      mreq_id_q    <= mreq_id_d;
      rsp_vld_q    <= rsp_vld_d;
      rsp_tid_q    <= rsp_tid_d;
      rsp_merged_q <= rsp_merged_d;
      err_q        <= err_d;
    end
  end

  assign bus.req_ready_o     = req_rdy;
  assign bus.rsp_valid_o     = rsp_vld_q;
  assign bus.rsp_tid_o       = rsp_tid_q;
  assign bus.rsp_merged_o    = rsp_merged_q;
  assign bus.mem_req_valid_o = mreq_vld_q;
  assign bus.mem_req_nline_o = mreq_nline_q;
  assign bus.mem_req_id_o    = mreq_id_q;
  assign busy_o              = any_busy || rsp_vld_q;
  assign err_o               = err_q;

endmodule
